// File: rtl/msgpass_addr_gen.sv
// msgpass_addr_gen: strided address bursts for the message-passing buffer with valid/ready handshake
module msgpass_addr_gen #(
  parameter int ADDR_WIDTH = 7,
  parameter int SRC_NUM = 2,
  parameter int SRC_SEL_WIDTH = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ADDR_WIDTH:0]           burst_len_i,
  input  logic [SRC_NUM*ADDR_WIDTH-1:0] stride_i,
  input  logic [SRC_SEL_WIDTH-1:0]      src_sel_i,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic                          addr_valid_o,
  input  logic                          addr_ready_i,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr, stride_sel;
  logic [ADDR_WIDTH:0] remaining;
  logic hs, go, one_left;
  assign go = (state == IDLE) && start_i && (burst_len_i != '0);
  assign hs = addr_valid_o && addr_ready_i;
  assign one_left = remaining == (ADDR_WIDTH+1)'(1);
  // out-of-range selects fall back to source 0
  always_comb begin
    stride_sel = stride_i[ADDR_WIDTH-1:0];
    for (int k = 0; k < SRC_NUM; k++)
      if (int'(src_sel_i) == k) stride_sel = stride_i[k*ADDR_WIDTH +: ADDR_WIDTH];
  end
  always_comb begin
    state_d = go ? RUN :
              (state == RUN && hs && one_left) ? DONE :
              (state == DONE) ? IDLE : state;
    addr_valid_o = state == RUN;
    last_o = (state == RUN) && one_left;
    busy_o = state != IDLE;
    done_o = state == DONE;
    addr_o = addr;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
    end else begin
      state <= state_d;
      if (go) begin
        addr <= base_addr_i;
        remaining <= burst_len_i;
      end else if (hs && !one_left) begin
        addr <= addr + stride_sel;
        remaining <= remaining - 1'b1;
      end
    end
  end
endmodule
